// File: rtl/dsi_video_tx_packetizer_pkg.sv
// Shared DSI video-mode constants and the sequencer state encoding.
package dsi_video_tx_packetizer_pkg;

    localparam logic [5:0] DT_VSS    = 6'h01;
    localparam logic [5:0] DT_HSS    = 6'h21;
    localparam logic [5:0] DT_RGB888 = 6'h3E;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LWAIT = 3'd1,
        ST_SREQ  = 3'd2,
        ST_LREQ  = 3'd3,
        ST_PAY   = 3'd4
    } state_t;

    // Line 0 of a frame carries VSS, every other line HSS.
    function automatic logic [5:0] sync_type(input logic first_line);
        return first_line ? DT_VSS : DT_HSS;
    endfunction

endpackage

// File: rtl/dsi_video_tx_packetizer_line_timer.sv
// Free-running line timer: produces the line-start event and remembers a
// line start that arrived while the sequencer was still busy with packets.
module dsi_video_tx_packetizer_line_timer #(
    parameter int LCNT_W = 16
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              run,
    input  logic              in_lwait,
    input  logic [LCNT_W-1:0] hline,
    output logic              go,
    output logic              timing_err
);

    localparam logic [LCNT_W-1:0] ONE = LCNT_W'(1);

    logic [LCNT_W-1:0] cnt_reg;
    logic              pending_reg;
    logic              timing_err_reg;
    logic              ls;
    logic              late_ls;

    assign ls         = run && (cnt_reg == '0);
    assign late_ls    = ls && !in_lwait;
    assign go         = in_lwait && (ls || pending_reg);
    assign timing_err = timing_err_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg        <= '0;
            pending_reg    <= 1'b0;
            timing_err_reg <= 1'b0;
        end else if (!run) begin
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            cnt_reg <= (cnt_reg >= hline - ONE) ? '0 : cnt_reg + ONE;
            // Only one late line start is remembered; further ones are dropped.
            if (late_ls) begin
                pending_reg    <= 1'b1;
                timing_err_reg <= 1'b1;
            end else if (in_lwait) begin
                pending_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dsi_video_tx_packetizer.sv
// DSI video-mode (sync-event) frame/line sequencer driving the host TX packet
// interface: one VSS/HSS per line plus an RGB888 long packet on active lines.
module dsi_video_tx_packetizer
    import dsi_video_tx_packetizer_pkg::*;
#(
    parameter logic [1:0] VC     = 2'd0,
    parameter int         LCNT_W = 16,
    parameter int         VCNT_W = 12
) (
    input  logic              TxByteClkHS,
    input  logic              rst,
    input  logic              enable,
    input  logic [VCNT_W-1:0] cfg_vsa,
    input  logic [VCNT_W-1:0] cfg_vbp,
    input  logic [VCNT_W-1:0] cfg_vact,
    input  logic [VCNT_W-1:0] cfg_vfp,
    input  logic [LCNT_W-1:0] cfg_hline,
    input  logic [15:0]       cfg_hact_bytes,
    input  logic              fifo_line_rdy,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [31:0]       fifo_rdata,
    output logic              host_tx_cmd_req,
    input  logic              host_tx_cmd_ack,
    output logic [1:0]        host_tx_cmd_vc,
    output logic [5:0]        host_tx_cmd_data_type,
    output logic [15:0]       host_tx_cmd_byte_count,
    output logic [31:0]       host_tx_payload,
    input  logic              host_tx_payload_en,
    input  logic              host_tx_payload_en_last,
    output logic              host_tx_hs_mode,
    output logic              host_tx_active,
    output logic              frame_done,
    output logic              underflow,
    output logic              timing_err
);

    localparam int            VW    = VCNT_W + 2;
    localparam logic [VW-1:0] V_ONE = VW'(1);

    state_t            state_reg;
    logic [VW-1:0]     v_reg;
    logic [VCNT_W-1:0] vsa_reg;
    logic [VCNT_W-1:0] vbp_reg;
    logic [VCNT_W-1:0] vact_reg;
    logic [VCNT_W-1:0] vfp_reg;
    logic [LCNT_W-1:0] hline_reg;
    logic [15:0]       bytes_reg;
    logic              req_reg;
    logic              active_reg;
    logic              frame_done_reg;
    logic              underflow_reg;
    logic [5:0]        dtype_reg;
    logic [15:0]       bcount_reg;

    logic [VW-1:0] total_lines;
    logic [VW-1:0] act_lo;
    logic [VW-1:0] act_hi;
    logic          line_active;
    logic          last_line;
    logic          in_pay;
    logic          pay_empty;
    logic          long_next;
    logic          line_end;
    logic          load_cfg;
    logic          run;
    logic          go;

    // Vertical geometry is evaluated two bits wider so the sum cannot wrap.
    assign total_lines = VW'(vsa_reg) + VW'(vbp_reg) + VW'(vact_reg) + VW'(vfp_reg);
    assign act_lo      = VW'(vsa_reg) + VW'(vbp_reg);
    assign act_hi      = act_lo + VW'(vact_reg);
    assign line_active = (v_reg >= act_lo) && (v_reg < act_hi);
    assign last_line   = (v_reg == total_lines - V_ONE);

    assign run       = (state_reg != ST_IDLE);
    assign in_pay    = (state_reg == ST_PAY);
    assign pay_empty = in_pay && host_tx_payload_en && fifo_empty;
    assign long_next = line_active && fifo_line_rdy;
    assign line_end  = ((state_reg == ST_SREQ) && host_tx_cmd_ack && !long_next) ||
                       (in_pay && host_tx_payload_en && host_tx_payload_en_last);
    assign load_cfg  = ((state_reg == ST_IDLE) && enable) || (line_end && last_line);

    // Payload path is combinational so the FWFT head is consumed in the same cycle.
    assign fifo_rd         = in_pay && host_tx_payload_en && !fifo_empty;
    assign host_tx_payload = (in_pay && !fifo_empty) ? fifo_rdata : 32'h0;

    assign host_tx_cmd_req        = req_reg;
    assign host_tx_cmd_vc         = VC;
    assign host_tx_cmd_data_type  = dtype_reg;
    assign host_tx_cmd_byte_count = bcount_reg;
    assign host_tx_hs_mode        = run;
    assign host_tx_active         = active_reg;
    assign frame_done             = frame_done_reg;
    assign underflow              = underflow_reg;

    dsi_video_tx_packetizer_line_timer #(
        .LCNT_W(LCNT_W)
    ) u_line_timer (
        .clk        (TxByteClkHS),
        .srst       (rst),
        .run        (run),
        .in_lwait   (state_reg == ST_LWAIT),
        .hline      (hline_reg),
        .go         (go),
        .timing_err (timing_err)
    );

    always_ff @(posedge TxByteClkHS) begin
        if (rst) begin
            vsa_reg   <= '0;
            vbp_reg   <= '0;
            vact_reg  <= '0;
            vfp_reg   <= '0;
            hline_reg <= '0;
            bytes_reg <= '0;
        end else if (load_cfg) begin
            vsa_reg   <= cfg_vsa;
            vbp_reg   <= cfg_vbp;
            vact_reg  <= cfg_vact;
            vfp_reg   <= cfg_vfp;
            hline_reg <= cfg_hline;
            bytes_reg <= cfg_hact_bytes;
        end
    end

    always_ff @(posedge TxByteClkHS) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            v_reg          <= '0;
            req_reg        <= 1'b0;
            active_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            underflow_reg  <= 1'b0;
            dtype_reg      <= '0;
            bcount_reg     <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            if (pay_empty) begin
                underflow_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        state_reg <= ST_LWAIT;
                        v_reg     <= '0;
                    end
                end
                ST_LWAIT: begin
                    if (go) begin
                        state_reg  <= ST_SREQ;
                        req_reg    <= 1'b1;
                        active_reg <= 1'b1;
                        dtype_reg  <= sync_type(v_reg == '0);
                        bcount_reg <= '0;
                    end
                end
                ST_SREQ: begin
                    if (host_tx_cmd_ack) begin
                        req_reg    <= 1'b0;
                        active_reg <= 1'b0;
                        if (long_next) begin
                            state_reg <= ST_LREQ;
                        end else if (line_active) begin
                            underflow_reg <= 1'b1;
                        end
                    end
                end
                ST_LREQ: begin
                    // Request is raised one cycle after the short packet's ack
                    // so the core always sees req drop between packets.
                    if (!req_reg) begin
                        req_reg    <= 1'b1;
                        active_reg <= 1'b1;
                        dtype_reg  <= DT_RGB888;
                        bcount_reg <= bytes_reg;
                    end else if (host_tx_cmd_ack) begin
                        req_reg   <= 1'b0;
                        state_reg <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (host_tx_payload_en && host_tx_payload_en_last) begin
                        active_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (line_end) begin
                if (last_line) begin
                    frame_done_reg <= 1'b1;
                    v_reg          <= '0;
                    state_reg      <= enable ? ST_LWAIT : ST_IDLE;
                end else begin
                    v_reg     <= v_reg + V_ONE;
                    state_reg <= ST_LWAIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsi_video_tx_packetizer.sv
// Directed bench: a small host-core responder acks packets and consumes
// payload words; each scenario task checks the logged traffic inline.
module tb_dsi_video_tx_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] cfg_vsa = '0, cfg_vbp = '0, cfg_vact = '0, cfg_vfp = '0;
    logic [15:0] cfg_hline = '0;
    logic [15:0] cfg_hact_bytes = '0;
    logic        fifo_line_rdy = 1'b1;
    logic        fifo_empty = 1'b0;
    logic        fifo_rd;
    logic [31:0] fifo_rdata;
    logic        req;
    logic        ack = 1'b0;
    logic [1:0]  vc;
    logic [5:0]  dtype;
    logic [15:0] bcount;
    logic [31:0] payload;
    logic        payload_en = 1'b0;
    logic        payload_en_last = 1'b0;
    logic        hs_mode;
    logic        active;
    logic        frame_done;
    logic        underflow;
    logic        timing_err;

    always #5 clk = ~clk;

    dsi_video_tx_packetizer dut (
        .TxByteClkHS             (clk),
        .rst                     (rst),
        .enable                  (enable),
        .cfg_vsa                 (cfg_vsa),
        .cfg_vbp                 (cfg_vbp),
        .cfg_vact                (cfg_vact),
        .cfg_vfp                 (cfg_vfp),
        .cfg_hline               (cfg_hline),
        .cfg_hact_bytes          (cfg_hact_bytes),
        .fifo_line_rdy           (fifo_line_rdy),
        .fifo_empty              (fifo_empty),
        .fifo_rd                 (fifo_rd),
        .fifo_rdata              (fifo_rdata),
        .host_tx_cmd_req         (req),
        .host_tx_cmd_ack         (ack),
        .host_tx_cmd_vc          (vc),
        .host_tx_cmd_data_type   (dtype),
        .host_tx_cmd_byte_count  (bcount),
        .host_tx_payload         (payload),
        .host_tx_payload_en      (payload_en),
        .host_tx_payload_en_last (payload_en_last),
        .host_tx_hs_mode         (hs_mode),
        .host_tx_active          (active),
        .frame_done              (frame_done),
        .underflow               (underflow),
        .timing_err              (timing_err)
    );

    int vec = 0;
    int errs = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FWFT FIFO model: head word is a recognisable pattern plus pop count.
    logic [15:0] fifo_head = '0;
    assign fifo_rdata = 32'hC0DE_0000 | {16'h0, fifo_head};
    always @(posedge clk) begin
        if (rst) fifo_head <= '0;
        else if (fifo_rd) fifo_head <= fifo_head + 16'd1;
    end

    int          pkt_type[$];
    int          pkt_cnt[$];
    int          pkt_t[$];
    logic [31:0] words[$];
    int          rd_cnt = 0, fd_cnt = 0, overlap = 0;
    int          ack_delay = 2, empty_at = -1, skip_idx = -1;

    // Host core responder: drives inputs at negedge, captures outputs 1 time unit later.
    initial begin
        int h, cnt_d, words_left;
        bit ack_just, cap;
        h = 0; cnt_d = 0; words_left = 0; ack_just = 0;
        forever begin
            @(negedge clk);
            ack = 1'b0; payload_en = 1'b0; payload_en_last = 1'b0; fifo_empty = 1'b0;
            cap = 0;
            if (rst) begin
                h = 0;
                ack_just = 0;
            end else begin
                if (ack_just && req) overlap++;
                ack_just = 0;
                if (h == 3) begin
                    fifo_empty = (words.size() == empty_at);
                    payload_en = 1'b1;
                    payload_en_last = (words_left == 1);
                    words_left--;
                    if (words_left == 0) h = 0;
                    cap = 1;
                end
                if (h == 1) begin
                    cnt_d--;
                    if (cnt_d == 0) begin
                        ack = 1'b1;
                        ack_just = 1;
                        if (pkt_cnt[$] != 0) begin
                            h = 3;
                            words_left = pkt_cnt[$] / 4;
                        end else begin
                            h = 0;
                        end
                    end
                end else if (h == 0 && req) begin
                    pkt_type.push_back(int'(dtype));
                    pkt_cnt.push_back(int'(bcount));
                    pkt_t.push_back(cyc);
                    cnt_d = ack_delay - 1;
                    h = 1;
                end
            end
            fifo_line_rdy = !(skip_idx >= 0 && pkt_type.size() - 1 == skip_idx);
            #1;
            if (fifo_rd) rd_cnt++;
            if (cap) words.push_back(payload);
            if (frame_done) fd_cnt++;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        empty_at = -1;
        skip_idx = -1;
        ack_delay = 2;
        repeat (3) @(posedge clk);
        pkt_type.delete(); pkt_cnt.delete(); pkt_t.delete(); words.delete();
        rd_cnt = 0; fd_cnt = 0; overlap = 0;
        #2 rst = 1'b0;
    endtask

    task automatic set_cfg(input int vsa, input int vbp, input int vact, input int vfp,
                           input int hline, input int bytes);
        cfg_vsa = 12'(vsa); cfg_vbp = 12'(vbp); cfg_vact = 12'(vact); cfg_vfp = 12'(vfp);
        cfg_hline = 16'(hline); cfg_hact_bytes = 16'(bytes);
    endtask

    task automatic wait_pkts(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (pkt_type.size() >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        set_cfg(1, 1, 2, 1, 64, 12);
        repeat (3) @(posedge clk);
        #2;
        vec++;
        if ({req, hs_mode, active, frame_done, underflow, timing_err, fifo_rd} !== 7'b0) begin
            errs++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {req, hs_mode, active, frame_done, underflow, timing_err, fifo_rd});
        end
        vec++;
        if ({vc, dtype, bcount, payload} !== 56'h0) begin
            errs++;
            $display("FAIL reset_bus: got vc=%h dt=%h bc=%h pl=%h want all 0", vc, dtype, bcount, payload);
        end
        $display("reset: flags=%b", {req, hs_mode, active, frame_done, underflow, timing_err});
        enable = 1'b0;
    endtask

    task automatic test_frame();
        bit ok;
        int exp_type[8];
        int exp_cnt[8];
        exp_type = '{'h01, 'h21, 'h21, 'h3E, 'h21, 'h3E, 'h21, 'h01};
        exp_cnt  = '{0, 0, 0, 12, 0, 12, 0, 0};
        do_reset();
        set_cfg(1, 1, 2, 1, 64, 12);
        enable = 1'b1;
        wait_pkts(8, 800, ok);
        vec++;
        if (!ok) begin errs++; $display("FAIL frame_timeout: got %0d pkts want 8", pkt_type.size()); end
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (pkt_type[i] !== exp_type[i] || pkt_cnt[i] !== exp_cnt[i]) begin
                errs++;
                $display("FAIL frame_pkt%0d: got dt=%h bc=%0d want dt=%h bc=%0d",
                         i, pkt_type[i], pkt_cnt[i], exp_type[i], exp_cnt[i]);
            end
            $display("frame pkt%0d: t=%0d dt=%h bc=%0d", i, pkt_t[i], pkt_type[i], pkt_cnt[i]);
        end
        vec++;
        if (pkt_t[7] - pkt_t[0] !== 320) begin
            errs++; $display("FAIL frame_period: got %0d want 320", pkt_t[7] - pkt_t[0]);
        end
        vec++;
        if (pkt_t[1] - pkt_t[0] !== 64) begin
            errs++; $display("FAIL line_period: got %0d want 64", pkt_t[1] - pkt_t[0]);
        end
        vec++;
        if (rd_cnt !== 6 || words.size() !== 6) begin
            errs++; $display("FAIL frame_fifo_rd: got rd=%0d words=%0d want 6/6", rd_cnt, words.size());
        end
        for (int i = 0; i < 6; i++) begin
            vec++;
            if (words[i] !== (32'hC0DE_0000 + 32'(i))) begin
                errs++; $display("FAIL frame_word%0d: got %h want %h", i, words[i], 32'hC0DE_0000 + 32'(i));
            end
        end
        vec++;
        if (fd_cnt !== 1 || overlap !== 0 || underflow !== 1'b0 || timing_err !== 1'b0 || hs_mode !== 1'b1) begin
            errs++;
            $display("FAIL frame_status: got fd=%0d ovl=%0d uf=%b te=%b hs=%b want 1 0 0 0 1",
                     fd_cnt, overlap, underflow, timing_err, hs_mode);
        end
    endtask

    task automatic test_no_line_rdy();
        bit ok;
        int exp_type[7];
        exp_type = '{'h01, 'h21, 'h21, 'h21, 'h3E, 'h21, 'h01};
        do_reset();
        set_cfg(1, 1, 2, 1, 64, 12);
        skip_idx = 2;
        enable = 1'b1;
        wait_pkts(7, 800, ok);
        vec++;
        if (!ok) begin errs++; $display("FAIL nordy_timeout: got %0d pkts want 7", pkt_type.size()); end
        for (int i = 0; i < 7; i++) begin
            vec++;
            if (pkt_type[i] !== exp_type[i]) begin
                errs++; $display("FAIL nordy_pkt%0d: got dt=%h want %h", i, pkt_type[i], exp_type[i]);
            end
        end
        $display("nordy: pkts=%0d rd=%0d uf=%b period=%0d", pkt_type.size(), rd_cnt, underflow, pkt_t[6] - pkt_t[0]);
        vec++;
        if (underflow !== 1'b1 || rd_cnt !== 3 || timing_err !== 1'b0) begin
            errs++; $display("FAIL nordy_flags: got uf=%b rd=%0d te=%b want 1 3 0", underflow, rd_cnt, timing_err);
        end
        vec++;
        if (pkt_t[6] - pkt_t[0] !== 320 || words[0] !== 32'hC0DE_0000 || words[2] !== 32'hC0DE_0002) begin
            errs++;
            $display("FAIL nordy_next_line: got period=%0d w0=%h w2=%h want 320 c0de0000 c0de0002",
                     pkt_t[6] - pkt_t[0], words[0], words[2]);
        end
    endtask

    task automatic test_fifo_empty();
        bit ok;
        logic [31:0] exp_w[6];
        exp_w = '{32'hC0DE_0000, 32'h0, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004};
        do_reset();
        set_cfg(1, 1, 2, 1, 64, 12);
        empty_at = 1;
        enable = 1'b1;
        wait_pkts(8, 800, ok);
        vec++;
        if (!ok) begin errs++; $display("FAIL empty_timeout: got %0d pkts want 8", pkt_type.size()); end
        for (int i = 0; i < 6; i++) begin
            vec++;
            if (words[i] !== exp_w[i]) begin
                errs++; $display("FAIL empty_word%0d: got %h want %h", i, words[i], exp_w[i]);
            end
        end
        $display("empty: words=%0d rd=%0d uf=%b", words.size(), rd_cnt, underflow);
        vec++;
        if (rd_cnt !== 5 || underflow !== 1'b1 || pkt_type[3] !== 'h3E || pkt_type[5] !== 'h3E) begin
            errs++;
            $display("FAIL empty_flags: got rd=%0d uf=%b dt3=%h dt5=%h want 5 1 3e 3e",
                     rd_cnt, underflow, pkt_type[3], pkt_type[5]);
        end
    endtask

    task automatic test_timing();
        bit ok;
        do_reset();
        set_cfg(1, 1, 1, 1, 16, 4);
        ack_delay = 20;
        enable = 1'b1;
        wait_pkts(2, 200, ok);
        vec++;
        if (!ok) begin errs++; $display("FAIL timing_timeout: got %0d pkts want 2", pkt_type.size()); end
        $display("timing: gap=%0d te=%b ovl=%0d", pkt_t[1] - pkt_t[0], timing_err, overlap);
        vec++;
        if (timing_err !== 1'b1) begin
            errs++; $display("FAIL timing_err: got %b want 1", timing_err);
        end
        vec++;
        if (pkt_t[1] - pkt_t[0] !== 21 || pkt_type[1] !== 'h21 || overlap !== 0) begin
            errs++;
            $display("FAIL timing_pending: got gap=%0d dt=%h ovl=%0d want 21 21 0",
                     pkt_t[1] - pkt_t[0], pkt_type[1], overlap);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        do_reset();
        set_cfg(1, 1, 2, 1, 64, 12);
        enable = 1'b1;
        wait_pkts(3, 400, ok);
        vec++;
        if (!ok) begin errs++; $display("FAIL endrop_timeout: got %0d pkts want 3", pkt_type.size()); end
        enable = 1'b0;
        repeat (500) @(negedge clk);
        #2;
        $display("endrop: pkts=%0d fd=%0d hs=%b req=%b", pkt_type.size(), fd_cnt, hs_mode, req);
        vec++;
        if (pkt_type.size() !== 7 || pkt_type[6] !== 'h21) begin
            errs++; $display("FAIL endrop_frame: got pkts=%0d last=%h want 7 21", pkt_type.size(), pkt_type[6]);
        end
        vec++;
        if (fd_cnt !== 1 || hs_mode !== 1'b0 || req !== 1'b0) begin
            errs++; $display("FAIL endrop_idle: got fd=%0d hs=%b req=%b want 1 0 0", fd_cnt, hs_mode, req);
        end
    endtask

    task automatic test_reset_in_pay();
        bit ok;
        do_reset();
        set_cfg(1, 1, 2, 1, 64, 12);
        empty_at = 0;
        enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (words.size() >= 2) begin
                ok = 1;
                break;
            end
        end
        vec++;
        if (!ok || {hs_mode, active, underflow} !== 3'b111) begin
            errs++;
            $display("FAIL rstpay_pre: got ok=%0d hs/act/uf=%b want 1 111", ok, {hs_mode, active, underflow});
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        $display("rstpay: flags=%b", {req, fifo_rd, hs_mode, active, underflow, timing_err, frame_done});
        vec++;
        if ({req, fifo_rd, hs_mode, active, underflow, timing_err, frame_done} !== 7'b0) begin
            errs++;
            $display("FAIL rstpay_flags: got %b want 0000000",
                     {req, fifo_rd, hs_mode, active, underflow, timing_err, frame_done});
        end
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (30) @(negedge clk);
        #2;
        vec++;
        if (req !== 1'b0 || hs_mode !== 1'b0) begin
            errs++; $display("FAIL rstpay_idle: got req=%b hs=%b want 0 0", req, hs_mode);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_no_line_rdy();
        test_fifo_empty();
        test_timing();
        test_enable_drop();
        test_reset_in_pay();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
